// File: rtl/memory_island_port_arbiter.sv
// memory_island_port_arbiter
//   Lets NumReq mem-style requesters share one request port of the memory
//   island core. The arbiter is round-robin. A requester that has been offered
//   the port but not yet granted by the core keeps it (lock) until the core
//   grants. Each issued request pushes the requester index into an in-order
//   tracking FIFO. Each core response pops the FIFO head and is routed back to
//   that requester in the same cycle.
//
// Ports
//   clk_i, rst_i            clock; asynchronous active-high reset
//   req_i/gnt_o             per-requester request and grant (grant is one-hot or zero)
//   addr_i/we_i/wdata_i/strb_i   packed per-requester request payloads
//   rvalid_o/rdata_o        per-requester response valid; data broadcast to all
//   out_*                   single core-side request/response port
//   outstanding_o           granted-but-unanswered request count
//   busy_o                  outstanding work or an active core request
//   err_o                   sticky protocol error (lock dropped, or stray response)
module memory_island_port_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned IdxWidth      = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1),
  localparam int unsigned PtrWidth      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  output logic [NumReq-1:0]             gnt_o,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*StrbWidth-1:0]   strb_i,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          out_req_o,
  input  logic                          out_gnt_i,
  output logic [AddrWidth-1:0]          out_addr_o,
  output logic                          out_we_o,
  output logic [DataWidth-1:0]          out_wdata_o,
  output logic [StrbWidth-1:0]          out_strb_o,
  input  logic                          out_rvalid_i,
  input  logic [DataWidth-1:0]          out_rdata_i,
  output logic [CntWidth-1:0]           outstanding_o,
  output logic                          busy_o,
  output logic                          err_o
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [IdxWidth-1:0]   r_sel;
  logic [IdxWidth-1:0]   w_sel_next;
  logic [IdxWidth-1:0]   r_rr_ptr;
  logic [CntWidth-1:0]   r_count;
  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [PtrWidth-1:0]   r_rd_ptr;
  logic                  r_err;
  logic [IdxWidth-1:0]   r_fifo [MaxOutstanding];

  logic [IdxWidth-1:0]   w_cand [NumReq];
  logic [AddrWidth-1:0]  w_addr_arr [NumReq];
  logic [DataWidth-1:0]  w_wdata_arr [NumReq];
  logic [StrbWidth-1:0]  w_strb_arr [NumReq];
  logic [IdxWidth-1:0]   w_scan_sel;
  logic                  w_scan_hit;
  logic [IdxWidth-1:0]   w_sel;
  logic [IdxWidth-1:0]   w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_locked;
  logic                  w_lock_err;
  logic                  w_out_req;
  logic                  w_issue;
  logic                  w_resp;
  logic                  w_stray;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Candidate order for the round-robin scan: rr_ptr, rr_ptr+1, ... with wrap.
  // Payloads are unpacked into arrays so the output mux indexes by requester.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    assign w_cand[gi]      = IdxWidth'((32'(r_rr_ptr) + 32'(gi)) % 32'(NumReq));
    assign w_addr_arr[gi]  = addr_i[gi*AddrWidth +: AddrWidth];
    assign w_wdata_arr[gi] = wdata_i[gi*DataWidth +: DataWidth];
    assign w_strb_arr[gi]  = strb_i[gi*StrbWidth +: StrbWidth];
  end

  // Scan in reverse so the candidate nearest rr_ptr is the last one written
  // and therefore wins.
  always_comb begin
    w_scan_hit = 1'b0;
    w_scan_sel = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (req_i[w_cand[k]]) begin
        w_scan_hit = 1'b1;
        w_scan_sel = w_cand[k];
      end
    end
  end

  assign w_locked   = (r_state == ST_LOCKED);
  assign w_full     = (r_count == CntWidth'(MaxOutstanding));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_sel      = w_locked ? r_sel : w_scan_sel;
  // A locked requester that withdraws its request is a protocol error.
  // The core request is also suppressed that cycle, so the core cannot accept
  // a request that has no grant behind it.
  assign w_lock_err = w_locked && !req_i[r_sel];
  assign w_out_req  = !rst_i && !w_full && !w_lock_err && (w_locked || w_scan_hit);
  assign w_issue    = w_out_req && out_gnt_i;
  assign w_resp     = !rst_i && out_rvalid_i && !w_empty;
  assign w_stray    = out_rvalid_i && w_empty;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_out
    assign gnt_o[gi]    = w_issue && (w_sel == IdxWidth'(gi));
    assign rvalid_o[gi] = w_resp && (w_head == IdxWidth'(gi));
  end

  // The payload and response data are forced to 0 while reset is high,
  // so every output is quiet during reset.
  assign out_req_o     = w_out_req;
  assign out_addr_o    = rst_i ? '0 : w_addr_arr[w_sel];
  assign out_we_o      = !rst_i && we_i[w_sel];
  assign out_wdata_o   = rst_i ? '0 : w_wdata_arr[w_sel];
  assign out_strb_o    = rst_i ? '0 : w_strb_arr[w_sel];
  assign rdata_o       = rst_i ? '0 : out_rdata_i;
  assign outstanding_o = r_count;
  assign busy_o        = (r_count != '0) || w_out_req;
  assign err_o         = r_err;

  // Lock FSM: next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    case (r_state)
      ST_IDLE: begin
        if (w_out_req && !out_gnt_i) begin
          w_state_next = ST_LOCKED;
          w_sel_next   = w_scan_sel;
        end
      end
      ST_LOCKED: begin
        if (w_lock_err || w_issue) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      if (w_lock_err || w_stray) begin
        r_err <= 1'b1;
      end
      if (w_issue) begin
        r_rr_ptr <= (w_sel == IdxWidth'(NumReq - 1)) ? '0 : w_sel + 1'b1;
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_resp) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      // A push and a pop in the same cycle leave the count unchanged.
      case ({w_issue, w_resp})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tracking storage holds no state that matters after reset, because the
  // pointers are cleared. It therefore needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_issue) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

endmodule
